// File: rtl/charrx_edge_pio.sv
// Avalon-MM input PIO for the character-receive path: synchronised input bus,
// per-bit edge detection, sticky W1C edge capture and a masked level interrupt.
module charrx_edge_pio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecapture_r;
    logic [WIDTH-1:0] sync_q_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [31:0]      rd_mux_s;
    logic             wr_en_s;
    logic             unused_wdata_s;

    assign sync_q_s       = sync_r[SYNC_STAGES-1];
    assign wr_en_s        = chipselect & ~write_n;
    // Bits above WIDTH are architecturally ignored.
    assign unused_wdata_s = ^writedata;

    // Input synchroniser chain and one-cycle history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_q_s;
        end
    end

    // Per-bit edge selection for the configured edge type.
    always_comb begin
        edge_s = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            32'sd0:  edge_s = sync_q_s & ~prev_r;
            32'sd1:  edge_s = ~sync_q_s & prev_r;
            32'sd2:  edge_s = sync_q_s ^ prev_r;
            default: edge_s = sync_q_s & ~prev_r;
        endcase
    end

    // Clear vector from an accepted write to the edgecapture word.
    always_comb begin
        clr_s = {WIDTH{1'b0}};
        if (wr_en_s && (address == 2'd2)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Interrupt mask and sticky capture; a same-cycle edge beats its clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r     <= {WIDTH{1'b0}};
            edgecapture_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_en_s && (address == 2'd1)) begin
                irqmask_r <= writedata[WIDTH-1:0];
            end
            edgecapture_r <= edge_s | (edgecapture_r & ~clr_s);
        end
    end

    // Read mux, zero-extended above WIDTH.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            2'd0:    rd_mux_s[WIDTH-1:0] = sync_q_s;
            2'd1:    rd_mux_s[WIDTH-1:0] = irqmask_r;
            2'd2:    rd_mux_s[WIDTH-1:0] = edgecapture_r;
            2'd3:    rd_mux_s[WIDTH-1:0] = edgecapture_r & irqmask_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read data is loaded every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= rd_mux_s;
        end
    end

    assign irq = |(edgecapture_r & irqmask_r);

endmodule

// File: tb/tb_charrx_edge_pio.sv
// Directed self-checking bench for charrx_edge_pio: rising, falling, any-edge
// and 32-bit builds sharing one bus and one reset.
module tb_charrx_edge_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    logic [7:0]  in_rise, in_fall, in_any;
    logic [31:0] in_w32;
    logic [31:0] rd_rise, rd_fall, rd_any, rd_w32;
    logic        irq_rise, irq_fall, irq_any, irq_w32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    charrx_edge_pio u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_rise),
        .readdata(rd_rise), .irq(irq_rise)
    );

    charrx_edge_pio #(.EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_fall),
        .readdata(rd_fall), .irq(irq_fall)
    );

    charrx_edge_pio #(.EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_any),
        .readdata(rd_any), .irq(irq_any)
    );

    charrx_edge_pio #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_w32),
        .readdata(rd_w32), .irq(irq_w32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_rise    = 8'hFF;
        in_fall    = 8'h00;
        in_any     = 8'h00;
        in_w32     = 32'd0;

        // Reset with inputs high
        tick(3);
        check("rst_readdata", rd_rise, 32'd0);
        check("rst_irq", {31'd0, irq_rise}, 32'd0);
        reset_n = 1'b1;
        bus_read(2'd0);
        check("post_rst_data_e1", rd_rise, 32'd0);
        bus_read(2'd2);
        check("post_rst_cap_e2", rd_rise, 32'd0);
        bus_read(2'd3);
        check("post_rst_pend_e3", rd_rise, 32'd0);
        bus_read(2'd2);
        check("post_rst_cap_ff", rd_rise, 32'h0000_00FF);
        check("post_rst_irq_masked", {31'd0, irq_rise}, 32'd0);
        bus_read(2'd0);
        check("post_rst_data_ff", rd_rise, 32'h0000_00FF);

        // Rising capture and interrupt on bit 0
        in_rise = 8'h00;
        tick(4);
        bus_write(2'd1, 32'h0000_0001);
        bus_write(2'd2, 32'h0000_00FF);
        bus_read(2'd2);
        check("cap_cleared", rd_rise, 32'd0);
        in_rise = 8'h01;
        tick(1);
        check("irq_e1", {31'd0, irq_rise}, 32'd0);
        tick(1);
        check("irq_e2", {31'd0, irq_rise}, 32'd0);
        tick(1);
        check("irq_e3", {31'd0, irq_rise}, 32'd1);
        bus_read(2'd2);
        check("cap_bit0", rd_rise, 32'h0000_0001);
        bus_read(2'd3);
        check("pend_bit0", rd_rise, 32'h0000_0001);
        bus_write(2'd2, 32'h0000_0001);
        check("irq_cleared", {31'd0, irq_rise}, 32'd0);
        bus_read(2'd2);
        check("cap_after_clr", rd_rise, 32'd0);

        // Edge on bit 3 lands on the same edge as its clear
        in_rise = 8'h09;
        tick(2);
        bus_write(2'd2, 32'h0000_0008);
        bus_read(2'd2);
        check("set_beats_clr", rd_rise, 32'h0000_0008);
        bus_write(2'd2, 32'h0000_0008);
        bus_read(2'd2);
        check("later_clr", rd_rise, 32'd0);

        // Falling and any-edge builds on bit 5
        in_fall = 8'h20;
        in_any  = 8'h20;
        tick(4);
        bus_read(2'd2);
        check("fall_on_rise", rd_fall, 32'd0);
        check("any_on_rise", rd_any, 32'h0000_0020);
        in_fall = 8'h00;
        in_any  = 8'h00;
        tick(4);
        bus_read(2'd2);
        check("fall_on_fall", rd_fall, 32'h0000_0020);
        check("any_on_fall", rd_any, 32'h0000_0020);

        // 32-bit build readback and ignored data write
        address = 2'd0;
        in_w32  = 32'hA5A5_5A5A;
        tick(2);
        check("w32_data_e2", rd_w32, 32'd0);
        tick(1);
        check("w32_data_e3", rd_w32, 32'hA5A5_5A5A);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0);
        check("w32_data_ro", rd_w32, 32'hA5A5_5A5A);
        bus_write(2'd1, 32'hFFFF_FF00);
        bus_read(2'd1);
        check("w8_mask_trunc", rd_rise, 32'd0);
        check("w32_mask_full", rd_w32, 32'hFFFF_FF00);

        // Mid-operation asynchronous reset
        in_rise = 8'h00;
        tick(4);
        in_rise = 8'hFF;
        tick(4);
        bus_write(2'd1, 32'h0000_00FF);
        bus_read(2'd2);
        check("mid_cap_ff", rd_rise, 32'h0000_00FF);
        check("mid_irq_high", {31'd0, irq_rise}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'd0, irq_rise}, 32'd0);
        check("async_readdata", rd_rise, 32'd0);
        check("async_cap", {24'd0, u_rise.edgecapture_r}, 32'd0);
        check("async_mask", {24'd0, u_rise.irqmask_r}, 32'd0);
        #3;
        reset_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
